pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline-stage register for the RV32 five-stage core, replacing the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries a control bundle and a data bundle under a valid/ready handshake. A two-entry skid buffer sustains full throughput with a registered `in_ready`. A synchronous flush inserts a bubble by clearing valid and control state, and a saturating counter reports flush events to the performance monitor.

## Interface
- `CTRL_W`, default 4: control-bundle width (e.g. MemWrite, RegWrite, ResultSrc[1:0]); these bits are cleared on bubble/flush.
- `DATA_W`, default 101: data-bundle width (e.g. ALUResult 32, WriteData 32, PC+4 32, Rd 5); these bits are never cleared except by reset.
- `CNT_W`, default 16: width of the flush counter.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream has a stage payload.
- `in_ready`  out  1  stage can accept a payload; registered.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `in_data`  in  DATA_W  upstream data bundle.
- `out_valid`  out  1  output payload valid; registered.
- `out_ready`  in  1  downstream accepts; hazard-unit stall drives this low.
- `out_ctrl`  out  CTRL_W  output control bundle; registered.
- `out_data`  out  DATA_W  output data bundle; registered.
- `flush`  in  1  synchronous flush (branch mispredict / exception).
- `occupancy`  out  2  entries held: 0, 1 or 2.
- `flush_count`  out  CNT_W  saturating count of cycles with `flush`=1.

## Operation
- Storage:
  - Main entry (M) drives `out_*` directly.
  - Skid entry (S) is internal.
  - Each entry holds valid, ctrl and data.
- push = `in_valid & in_ready`. pop = `out_valid & out_ready`.
- States are encoded by occupancy:
  - EMPTY (0): only M is usable.
  - ONE (1): M is valid.
  - FULL (2): M and S are valid.
- Transitions, when `flush`=0:
  - EMPTY: push -> ONE, M <= in.
  - ONE: push & pop -> ONE, M <= in.
  - ONE: push & !pop -> FULL, S <= in.
  - ONE: pop & !push -> EMPTY.
  - ONE: neither -> hold.
  - FULL: no push is possible (`in_ready`=0).
  - FULL: pop -> ONE, M <= S, S.ctrl <= 0.
  - FULL: no pop -> hold.
- `flush`=1 overrides all of the above:
  - Next state is EMPTY.
  - M.valid, S.valid, M.ctrl and S.ctrl are all set to 0.
  - Data fields hold their values.
  - A push in the same cycle is discarded.
  - A pop in the same cycle still counts as consumed by downstream.
- Bubble rule: whenever an entry becomes empty, its ctrl is set to 0. Consequence: `out_ctrl` == 0 in every cycle where `out_valid` == 0. `out_data` holds its last value.
- Payloads leave in FIFO order. No payload is duplicated or lost unless `flush` is asserted.
- `in_ready` next = (next state != FULL).
- `flush_count` increments by 1 each cycle `flush`=1 and saturates at 2^CNT_W−1. No wrap.
- Reset values (async, immediate):
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0.
  - `in_ready`=1, `occupancy`=0, `flush_count`=0.
  - S cleared to 0.

## Timing
- Latency: push in cycle N -> `out_valid`=1 with that payload in cycle N+1 (from EMPTY, or from ONE with a simultaneous pop).
- Throughput: 1 payload/cycle sustained when `out_ready`=1.
- No combinational path from any input to any output. In particular, `out_ready` does not reach `in_ready` combinationally.
- `out_ready` deasserted for one cycle in steady flow:
  - The stage fills to FULL.
  - `in_ready` drops one cycle later.
  - No payload is lost.
- Flush takes effect at the next rising edge: `out_valid`=0 and `out_ctrl`=0 in the cycle after `flush`=1.
- Reset asserted mid-transfer:
  - All outputs go to reset values asynchronously.
  - Release is synchronous to the first `clk` edge after `rst_n` rises.
  - The first push is accepted on that edge if `in_valid`=1.

## Test plan
- Reset check: during reset `out_valid`=0, `out_ctrl`=0, `out_data`=0, `in_ready`=1, `occupancy`=0. After release, push ctrl=4'hB, data=0x1 -> next cycle `out_valid`=1, `out_ctrl`=4'hB, `out_data`=0x1.
- Streaming: push 8 payloads, data 0x10..0x17, with `out_ready`=1 throughout -> outputs appear in order with 1-cycle latency and no gaps; `occupancy` stays 1.
- Backpressure:
  - Stream 0x20..0x23 and drop `out_ready` for 2 cycles.
  - -> `occupancy` reaches 2 and `in_ready`=0 for those cycles.
  - -> After release, all four payloads emerge in order, none lost or duplicated.
- Flush with FULL state and a concurrent push:
  - Setup: FULL state holding 0x30 and 0x31, `in_valid`=1 with 0x32, `flush`=1.
  - -> Next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, `in_ready`=1, `flush_count`=1.
  - -> 0x30, 0x31 and 0x32 never appear at the output.
- Flush counter saturation: with CNT_W=3, hold `flush`=1 for 10 cycles -> `flush_count` reads 7 and stays at 7.
- Async reset mid-stream: assert `rst_n`=0 between clock edges while FULL -> outputs clear immediately, without waiting for an edge. After release, the stream restarts cleanly from EMPTY.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: a control bundle and a data bundle carried
// under a valid/ready handshake, backed by a two-entry skid buffer so that
// in_ready can be registered without losing throughput.
//
// Handshake: a payload moves across a port on a rising edge where valid and
// ready are both 1 on that port. Valid never depends on ready. in_ready and
// out_valid come straight from flops, so no input reaches an output
// combinationally.
module pipe_stage_reg #(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 101,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_count
);

    // The state value is the number of entries held, so it doubles as the
    // occupancy output.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic                m_valid_q;
    logic                in_ready_q;
    logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [CTRL_W-1:0]   s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0]   s_data_q, s_data_d;
    logic [CNT_W-1:0]    flush_count_q;
    logic                push;
    logic                pop;

    assign push = in_valid & in_ready_q;
    assign pop  = m_valid_q & out_ready;

    // Next-state and entry update; flush overrides everything, and any entry
    // that goes empty has its control bits cleared so it reads as a bubble.
    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;
        if (flush) begin
            state_d  = EMPTY;
            m_ctrl_d = '0;
            s_ctrl_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d  = ONE;
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end else if (push) begin
                        state_d  = FULL;
                        s_ctrl_d = in_ctrl;
                        s_data_d = in_data;
                    end else if (pop) begin
                        state_d  = EMPTY;
                        m_ctrl_d = '0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_d  = ONE;
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                        s_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State, entry storage and the registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            m_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
            m_ctrl_q   <= '0;
            m_data_q   <= '0;
            s_ctrl_q   <= '0;
            s_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            m_valid_q  <= (state_d != EMPTY);
            in_ready_q <= (state_d != FULL);
            m_ctrl_q   <= m_ctrl_d;
            m_data_q   <= m_data_d;
            s_ctrl_q   <= s_ctrl_d;
            s_data_q   <= s_data_d;
        end
    end

    // Saturating count of flush cycles for the performance monitor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_count_q <= '0;
        end else if (flush && (flush_count_q != CNT_MAX)) begin
            flush_count_q <= flush_count_q + CNT_ONE;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = m_valid_q;
    assign out_ctrl    = m_ctrl_q;
    assign out_data    = m_data_q;
    assign occupancy   = state_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vectors, a queue-based reference model
// checked every cycle, and literal expectations at key points.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 4;
    localparam int DATA_W = 101;
    localparam int CNT_W  = 3;
    localparam int W      = CTRL_W + DATA_W;
    localparam int FC_MAX = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  flush_count;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .flush      (flush),
        .occupancy  (occupancy),
        .flush_count(flush_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Payloads held by the stage in arrival order; head is what is on out_*.
    logic [W-1:0]      exp_q[$];
    logic [DATA_W-1:0] mdl_last_data = '0;
    int                mdl_fc = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit do_push;
        bit do_pop;
        if (!rst_n) begin
            exp_q.delete();
            mdl_last_data = '0;
            mdl_fc        = 0;
        end else begin
            do_push = in_valid && (exp_q.size() < 2);
            do_pop  = (exp_q.size() > 0) && out_ready;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (do_pop) void'(exp_q.pop_front());
                if (do_push) exp_q.push_back({in_ctrl, in_data});
            end
            if (exp_q.size() > 0) mdl_last_data = exp_q[0][DATA_W-1:0];
            if (flush && mdl_fc < FC_MAX) mdl_fc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        logic [W-1:0] head;
        bit           have;
        have = (exp_q.size() > 0);
        head = have ? exp_q[0] : '0;
        check("cyc_out_valid", out_valid, have);
        check("cyc_out_ctrl", out_ctrl, have ? head[W-1:DATA_W] : '0);
        check("cyc_out_data", out_data, have ? head[DATA_W-1:0] : mdl_last_data);
        check("cyc_in_ready", in_ready, exp_q.size() < 2);
        check("cyc_occupancy", occupancy, exp_q.size());
        check("cyc_flush_count", flush_count, mdl_fc);
    end

    // ---------------- driver ----------------
    // Inputs change on the falling edge, so the rising edge sees stable values;
    // returns on the next falling edge with the outputs of that rising edge.
    task automatic step(input logic iv, input logic [CTRL_W-1:0] c,
                        input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, ordy, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_ctrl", out_ctrl, 4'h0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_occupancy", occupancy, 2'd0);
        check("rst_flush_count", flush_count, 0);

        // First push after release is taken on the first edge
        rst_n = 1'b1;
        step(1'b1, 4'hB, 101'h1, 1'b1, 1'b0);
        check("first_out_valid", out_valid, 1'b1);
        check("first_out_ctrl", out_ctrl, 4'hB);
        check("first_out_data", out_data, 101'h1);
        idle(1'b1);
        check("drain_out_valid", out_valid, 1'b0);
        check("drain_out_ctrl", out_ctrl, 4'h0);
        check("drain_out_data_hold", out_data, 101'h1);

        // Streaming: 1-cycle latency, no gaps, occupancy stays 1
        for (int i = 0; i < 8; i++) begin
            step(1'b1, CTRL_W'(i + 1), DATA_W'(32'h10 + i), 1'b1, 1'b0);
            check("stream_out_valid", out_valid, 1'b1);
            check("stream_out_data", out_data, 32'h10 + i);
            check("stream_occupancy", occupancy, 2'd1);
        end
        idle(1'b1);

        // Backpressure: out_ready low for two cycles
        step(1'b1, 4'h2, 101'h20, 1'b1, 1'b0);
        check("bp_head", out_data, 101'h20);
        step(1'b1, 4'h3, 101'h21, 1'b0, 1'b0);
        check("bp_occ_full0", occupancy, 2'd2);
        check("bp_in_ready0", in_ready, 1'b0);
        step(1'b1, 4'h4, 101'h22, 1'b0, 1'b0);
        check("bp_occ_full1", occupancy, 2'd2);
        check("bp_in_ready1", in_ready, 1'b0);
        check("bp_head_held", out_data, 101'h20);
        step(1'b1, 4'h4, 101'h22, 1'b1, 1'b0);
        check("bp_after_release", out_data, 101'h21);
        check("bp_in_ready_back", in_ready, 1'b1);
        step(1'b1, 4'h4, 101'h22, 1'b1, 1'b0);
        check("bp_third", out_data, 101'h22);
        step(1'b1, 4'h5, 101'h23, 1'b1, 1'b0);
        check("bp_fourth", out_data, 101'h23);
        idle(1'b1);
        check("bp_drained", out_valid, 1'b0);

        // Flush while FULL with a concurrent push
        step(1'b1, 4'h6, 101'h30, 1'b0, 1'b0);
        step(1'b1, 4'h7, 101'h31, 1'b0, 1'b0);
        check("fl_setup_full", occupancy, 2'd2);
        step(1'b1, 4'h8, 101'h32, 1'b0, 1'b1);
        check("fl_out_valid", out_valid, 1'b0);
        check("fl_out_ctrl", out_ctrl, 4'h0);
        check("fl_occupancy", occupancy, 2'd0);
        check("fl_in_ready", in_ready, 1'b1);
        check("fl_count", flush_count, 1);
        idle(1'b1);
        idle(1'b1);
        check("fl_nothing_emerges", out_valid, 1'b0);
        step(1'b1, 4'h9, 101'h40, 1'b1, 1'b0);
        check("fl_restart", out_data, 101'h40);
        idle(1'b1);

        // Flush counter saturation (CNT_W = 3)
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b1, 1'b1);
        check("sat_count", flush_count, 7);
        idle(1'b1);
        check("sat_count_hold", flush_count, 7);

        // Async reset mid-stream while FULL
        step(1'b1, 4'hA, 101'h50, 1'b0, 1'b0);
        step(1'b1, 4'hC, 101'h51, 1'b0, 1'b0);
        check("ar_full", occupancy, 2'd2);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 1'b0);
        check("ar_out_ctrl", out_ctrl, 4'h0);
        check("ar_out_data", out_data, 0);
        check("ar_in_ready", in_ready, 1'b1);
        check("ar_occupancy", occupancy, 2'd0);
        check("ar_flush_count", flush_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4'hD, 101'h60, 1'b1, 1'b0);
        check("ar_restart0", out_data, 101'h60);
        check("ar_restart_ctrl", out_ctrl, 4'hD);
        step(1'b1, 4'hE, 101'h61, 1'b1, 1'b0);
        check("ar_restart1", out_data, 101'h61);
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
